pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised elastic pipeline-stage register: successor to the fixed IF/ID latch.
//  - Carries an arbitrary payload plus a valid bit between two stages.
//  - Uses a valid/ready handshake and a one-entry skid buffer, so in_ready is a registered-state signal.
//  - Supports flush and stall. Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB.
// PARAMETERS
//  PAYLOAD_W  35  payload width in bits; default = pc[15:0], instr[15:0], rsValid, rtValid, writeRegValid
//  SKID_EN    1   1: two entries (main + skid), full throughput; 0: main only, in_ready = ~full | out_ready
//  RST_VAL    0   reset/flush value loaded into the payload registers (PAYLOAD_W bits)
// PORTS
//  clk        in   1          clock; all state updates on the rising edge
//  rst        in   1          synchronous reset, active-high
//  in_valid   in   1          upstream presents a valid payload
//  in_ready   out  1          stage can accept a payload this cycle
//  in_data    in   PAYLOAD_W  upstream payload
//  flush      in   1          discard all held entries and any incoming payload this cycle
//  out_valid  out  1          out_data holds a valid payload
//  out_ready  in   1          downstream accepts out_data this cycle (0 = stall)
//  out_data   out  PAYLOAD_W  registered payload (main entry)
//  stall_cnt  out  16         stall-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset:
//  - rst=1 at an edge: state=EMPTY, out_valid=0, out_data=RST_VAL, skid=RST_VAL, stall_cnt=0.
//  - in_ready=1 from the first cycle after reset.
//  Handshake:
//  - Accept = in_valid & in_ready. Drain = out_valid & out_ready.
//  - out_data and out_valid are outputs of flops only; latency in->out = 1 cycle.
//  States (SKID_EN=1):
//  - EMPTY (out_valid=0, in_ready=1): accept -> FULL, main<=in_data.
//  - FULL  (out_valid=1, in_ready=1):
//    - accept & drain -> FULL, main<=in_data.
//    - drain only -> EMPTY.
//    - accept only -> SKID, skid<=in_data.
//  - SKID  (out_valid=1, in_ready=0): drain -> FULL, main<=skid.
//  - SKID_EN=0: state SKID unused. in_ready = (state==EMPTY) | out_ready; FULL with accept & drain stays FULL.
//  Ordering: payloads leave in acceptance order; no drop or duplicate unless flush.
//  Stall: out_ready=0 holds out_data/out_valid stable every cycle (the legacy writeIfId=0 behaviour).
//  Flush (priority over everything except rst):
//  - Next state=EMPTY, out_valid=0, main and skid <= RST_VAL.
//  - A same-cycle in_valid payload is dropped; a same-cycle drain still counts for downstream.
//  rst during a transfer: all entries discarded, identical to flush, and stall_cnt also cleared.
//  Width: payload is opaque; no field interpretation inside the block.
// CONFIGURATION
//  PIPE_STAGE_STALL_CNT_EN defined:
//  - stall_cnt += 1 every cycle with out_valid & ~out_ready.
//  - Saturates at 16'hFFFF; cleared by rst only, not by flush.
//  Not defined: stall_cnt tied to 16'h0000 and no counter flops are synthesised.
// STRUCTURE
//  pipe_pkg:
//  - Enum pipe_state_t {EMPTY, FULL, SKID}.
//  - Localparams for the IF/ID payload layout: PC_LSB=19, INSTR_LSB=3, RSV_BIT=2, RTV_BIT=1, WRV_BIT=0, IFID_PAYLOAD_W=35.
//  Sub-module pipe_stage_entry: PAYLOAD_W-wide load-enable register with synchronous clear.
//  - Instantiated once for main and once for skid (skid only when SKID_EN=1).
// TESTING
//  1. rst=1 for 2 cycles, then rst=0 -> out_valid=0, in_ready=1, out_data=0, stall_cnt=0.
//  2. Streaming: in_valid=1 with data 1,2,3,4 and out_ready=1 -> out_data 1,2,3,4 one cycle later, in_ready always 1.
//  3. Stall: send 0xA then 0xB while out_ready=0 -> SKID, in_ready=0, out_data=0xA held.
//     Raise out_ready -> 0xA then 0xB, no loss.
//  4. Flush in SKID with in_valid=1 data 0xC -> next cycle out_valid=0, in_ready=1; 0xC never appears.
//  5. rst asserted in the cycle after 0x5 is accepted -> out_valid=0 next cycle; 0x5 never appears.
//  6. With PIPE_STAGE_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF.
//     Without the macro -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and payload layout for the elastic pipeline-stage registers.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package pipe_pkg;

  // Occupancy of one stage: nothing held, main entry held, main and skid held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  // IF/ID payload layout: pc[15:0], instr[15:0], rsValid, rtValid, writeRegValid.
  localparam int PC_LSB         = 19;
  localparam int INSTR_LSB      = 3;
  localparam int RSV_BIT        = 2;
  localparam int RTV_BIT        = 1;
  localparam int WRV_BIT        = 0;
  localparam int IFID_PAYLOAD_W = 35;

endpackage

// File: rtl/pipe_stage_entry.sv
// One payload entry: load-enable register with synchronous clear to RST_VAL.
// Latency: 1 cycle from load to value.
// Backpressure: none; the owner decides when to load.
module pipe_stage_entry #(
  parameter int                   PAYLOAD_W = 35,
  parameter logic [PAYLOAD_W-1:0] RST_VAL   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] data,
  output logic [PAYLOAD_W-1:0] value
);

  // Reset and clear share the same reload value; clear wins over load.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= RST_VAL;
    end else if (load) begin
      value <= data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register (main + optional skid entry) with flush; optional stall counter under PIPE_STAGE_STALL_CNT_EN.
// Latency: 1 cycle in_data -> out_data; out_valid/out_data come straight from flops.
// Backpressure: out_ready=0 holds the output; with SKID_EN the skid entry absorbs one extra beat and in_ready depends only on state.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                   PAYLOAD_W = IFID_PAYLOAD_W,
  parameter int                   SKID_EN   = 1,
  parameter logic [PAYLOAD_W-1:0] RST_VAL   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [15:0]          stall_cnt
);

  pipe_state_t          state;
  pipe_state_t          nextState;
  logic                 outValidQ;
  logic                 accept;
  logic                 drain;
  logic                 mainLoad;
  logic                 skidLoad;
  logic [PAYLOAD_W-1:0] mainNext;
  logic [PAYLOAD_W-1:0] mainQ;
  logic [PAYLOAD_W-1:0] skidQ;

  // With a skid entry, ready is a pure function of the state register;
  // without it, a full stage can only take a beat while one leaves.
  assign in_ready  = (SKID_EN != 0) ? (state != SKID)
                                    : ((state == EMPTY) || out_ready);
  assign accept    = in_valid && in_ready;
  assign drain     = outValidQ && out_ready;
  assign out_valid = outValidQ;
  assign out_data  = mainQ;

  // State register; rst and flush both return the stage to EMPTY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  // out_valid kept as its own flop so the output is not decoded from state.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValidQ <= 1'b0;
    end else begin
      outValidQ <= (nextState != EMPTY);
    end
  end

  // Next-state and entry load controls; flush overrides every transition.
  always_comb begin
    nextState = state;
    mainLoad  = 1'b0;
    skidLoad  = 1'b0;
    mainNext  = in_data;
    if (flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            nextState = FULL;
            mainLoad  = 1'b1;
          end
        end
        FULL: begin
          if (accept && drain) begin
            mainLoad = 1'b1;
          end else if (drain) begin
            nextState = EMPTY;
          end else if (accept && (SKID_EN != 0)) begin
            nextState = SKID;
            skidLoad  = 1'b1;
          end
        end
        SKID: begin
          if (drain) begin
            nextState = FULL;
            mainLoad  = 1'b1;
            mainNext  = skidQ;
          end
        end
        default: begin
          nextState = EMPTY;
        end
      endcase
    end
  end

  pipe_stage_entry #(
    .PAYLOAD_W (PAYLOAD_W),
    .RST_VAL   (RST_VAL)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (mainLoad),
    .data  (mainNext),
    .value (mainQ)
  );

  generate
    if (SKID_EN != 0) begin : g_skid
      pipe_stage_entry #(
        .PAYLOAD_W (PAYLOAD_W),
        .RST_VAL   (RST_VAL)
      ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .load  (skidLoad),
        .data  (in_data),
        .value (skidQ)
      );
    end else begin : g_noskid
      assign skidQ = RST_VAL;
    end
  endgenerate

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stallCntQ;

  // Saturating count of cycles where a held beat is refused; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCntQ <= 16'h0000;
    end else if (outValidQ && !out_ready && (stallCntQ != 16'hFFFF)) begin
      stallCntQ <= stallCntQ + 16'h0001;
    end
  end

  assign stall_cnt = stallCntQ;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table plus stall-counter sequence.
// Latency: checks pre-edge outputs each cycle, inputs driven on the falling edge.
// Backpressure: exercised through out_ready patterns in the table.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
  localparam int HOLD   = 70000;
`else
  localparam bit CNT_EN = 1'b0;
  localparam int HOLD   = 20;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [34:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [34:0] out_data;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        inV;
    logic [34:0] inD;
    logic        outR;
    logic        chk;
    logic        chkD;
    logic        expV;
    logic        expR;
    logic [34:0] expD;
  } vec_t;

  vec_t vecs[$];

  task automatic addV(input logic r, input logic f, input logic v, input logic [34:0] d,
                      input logic o, input logic c, input logic cd, input logic ev,
                      input logic er, input logic [34:0] ed);
    vec_t t;
    t.rst = r; t.flush = f; t.inV = v; t.inD = d; t.outR = o;
    t.chk = c; t.chkD = cd; t.expV = ev; t.expR = er; t.expD = ed;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h required 0x%0h", name, idx, act, exp);
    end
  endtask

  logic [15:0] expCnt;
  int          total;
  logic [15:0] holdExp;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    expCnt = 16'h0000;

    //    rst  fl   inV  inD     oR   chk  chkD expV expR expD
    // reset, then idle
    addV(1'b1, 1'b0, 1'b0, 35'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 35'h0);
    addV(1'b1, 1'b0, 1'b0, 35'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 35'h0);
    addV(1'b0, 1'b0, 1'b0, 35'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 35'h0);
    // streaming 1..4
    addV(1'b0, 1'b0, 1'b1, 35'h1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 35'h0);
    addV(1'b0, 1'b0, 1'b1, 35'h2,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 35'h1);
    addV(1'b0, 1'b0, 1'b1, 35'h3,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 35'h2);
    addV(1'b0, 1'b0, 1'b1, 35'h4,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 35'h3);
    addV(1'b0, 1'b0, 1'b0, 35'h0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 35'h4);
    addV(1'b0, 1'b0, 1'b0, 35'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 35'h0);
    // stall into SKID with 0xA, 0xB, then release
    addV(1'b0, 1'b0, 1'b1, 35'hA,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 35'h0);
    addV(1'b0, 1'b0, 1'b1, 35'hB,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 35'hA);
    addV(1'b0, 1'b0, 1'b0, 35'h0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 35'hA);
    addV(1'b0, 1'b0, 1'b0, 35'h0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 35'hA);
    addV(1'b0, 1'b0, 1'b0, 35'h0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 35'hA);
    addV(1'b0, 1'b0, 1'b0, 35'h0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 35'hB);
    addV(1'b0, 1'b0, 1'b0, 35'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 35'h0);
    // flush while in SKID with 0xC offered; flush dropping an accepted beat
    addV(1'b0, 1'b0, 1'b1, 35'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 35'h0);
    addV(1'b0, 1'b0, 1'b1, 35'h12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 35'h11);
    addV(1'b0, 1'b1, 1'b1, 35'hC,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 35'h11);
    addV(1'b0, 1'b0, 1'b0, 35'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 35'h0);
    addV(1'b0, 1'b0, 1'b0, 35'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 35'h0);
    addV(1'b0, 1'b1, 1'b1, 35'h21, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 35'h0);
    addV(1'b0, 1'b0, 1'b0, 35'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 35'h0);
    // rst the cycle after 0x5 is accepted
    addV(1'b0, 1'b0, 1'b1, 35'h5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 35'h0);
    addV(1'b1, 1'b0, 1'b0, 35'h0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 35'h5);
    addV(1'b0, 1'b0, 1'b0, 35'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 35'h0);
    // SKID refill while draining, then accept & drain in FULL
    addV(1'b0, 1'b0, 1'b1, 35'h31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 35'h0);
    addV(1'b0, 1'b0, 1'b1, 35'h32, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 35'h31);
    addV(1'b0, 1'b0, 1'b1, 35'h33, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 35'h31);
    addV(1'b0, 1'b0, 1'b1, 35'h33, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 35'h32);
    addV(1'b0, 1'b0, 1'b0, 35'h0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 35'h33);
    addV(1'b0, 1'b0, 1'b0, 35'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 35'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      flush     = vecs[i].flush;
      in_valid  = vecs[i].inV;
      in_data   = vecs[i].inD;
      out_ready = vecs[i].outR;
      #1;
      if (vecs[i].chk) begin
        check("out_valid", i, 35'(out_valid), 35'(vecs[i].expV));
        check("in_ready",  i, 35'(in_ready),  35'(vecs[i].expR));
        check("stall_cnt", i, 35'(stall_cnt), 35'(expCnt));
        if (vecs[i].chkD) begin
          check("out_data", i, out_data, vecs[i].expD);
        end
      end
      if (vecs[i].rst) begin
        expCnt = 16'h0000;
      end else if (CNT_EN && vecs[i].expV && !vecs[i].outR && (expCnt != 16'hFFFF)) begin
        expCnt = expCnt + 16'h0001;
      end
    end

    // Long stall: one beat held against out_ready=0 for HOLD cycles.
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 35'h77; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_data = 35'h0;
    repeat (HOLD) @(negedge clk);
    #1;
    total   = int'(expCnt) + HOLD;
    holdExp = !CNT_EN ? 16'h0000 : (total > 65535) ? 16'hFFFF : 16'(total);
    check("hold_out_valid", 0, 35'(out_valid), 35'h1);
    check("hold_out_data",  0, out_data, 35'h77);
    check("hold_stall_cnt", 0, 35'(stall_cnt), 35'(holdExp));
    @(negedge clk);
    #1;
    check("hold_stall_cnt", 1, 35'(stall_cnt), 35'(holdExp));
    out_ready = 1'b1;
    #1;
    check("hold_in_ready", 0, 35'(in_ready), 35'h1);
    @(negedge clk);
    #1;
    check("hold_drained", 0, 35'(out_valid), 35'h0);
    check("hold_stall_cnt", 2, 35'(stall_cnt), 35'(holdExp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
